// File: rtl/morse_decoder.sv
// morse_decoder: measures mark/space durations on a single-bit morse line,
// classifies marks as dot or dash and decodes each symbol group into a 3-bit
// letter code (S=000 .. Z=111).
// Optional feature: define MORSE_DECODER_DEBOUNCE_EN to insert a level
// debouncer (DEBOUNCE_CYCLES stable cycles) between the synchroniser and the FSM.
module morse_decoder #(
    parameter int unsigned UNIT_CYCLES     = 25_000_000,
    parameter int unsigned DEBOUNCE_CYCLES = 500_000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       morse_in,
    output logic [2:0] letter,
    output logic       letter_valid,
    output logic       decode_error,
    output logic       busy
);
    localparam int unsigned      CNT_MAX  = 4 * UNIT_CYCLES;
    localparam int unsigned      CNT_W    = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(CNT_MAX);
    localparam logic [CNT_W-1:0] DASH_MIN = CNT_W'(2 * UNIT_CYCLES);
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(2 * UNIT_CYCLES - 1);

    // Reject configurations the timing logic cannot represent.
    if (UNIT_CYCLES < 1 || DEBOUNCE_CYCLES < 1) begin : g_bad_cfg
        $error("morse_decoder: UNIT_CYCLES and DEBOUNCE_CYCLES must be >= 1");
    end

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_MARK   = 2'd1,
        ST_SPACE  = 2'd2,
        ST_DECODE = 2'd3
    } state_e;

    // Map a completed group (symbols LSB-first, 1 = dash) to {hit, letter code}.
    function automatic logic [3:0] decode_group(input logic [3:0] pat, input logic [2:0] n);
        logic [3:0] res;
        case ({n, pat})
            {3'd3, 4'b0000}: res = {1'b1, 3'b000}; // S ...
            {3'd1, 4'b0001}: res = {1'b1, 3'b001}; // T -
            {3'd3, 4'b0100}: res = {1'b1, 3'b010}; // U ..-
            {3'd4, 4'b1000}: res = {1'b1, 3'b011}; // V ...-
            {3'd3, 4'b0110}: res = {1'b1, 3'b100}; // W .--
            {3'd4, 4'b1001}: res = {1'b1, 3'b101}; // X -..-
            {3'd4, 4'b1101}: res = {1'b1, 3'b110}; // Y -.--
            {3'd4, 4'b0011}: res = {1'b1, 3'b111}; // Z --..
            default:         res = {1'b0, 3'b000};
        endcase
        return res;
    endfunction

    logic sync1_q, sync_q;
    logic level_s;

    // Two-flop synchroniser for the asynchronous morse line.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync1_q <= 1'b0;
            sync_q  <= 1'b0;
        end else begin
            sync1_q <= morse_in;
            sync_q  <= sync1_q;
        end
    end

`ifdef MORSE_DECODER_DEBOUNCE_EN
    localparam int unsigned     DB_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

    logic            filt_q, filt_d;
    logic [DB_W-1:0] db_cnt_q, db_cnt_d;

    // Adopt a new level only after it has been held for DEBOUNCE_CYCLES cycles.
    always_comb begin
        filt_d   = filt_q;
        db_cnt_d = db_cnt_q;
        if (sync_q == filt_q) begin
            db_cnt_d = '0;
        end else if (db_cnt_q == DB_LAST) begin
            filt_d   = sync_q;
            db_cnt_d = '0;
        end else begin
            db_cnt_d = db_cnt_q + DB_W'(1);
        end
    end

    // Debouncer state registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            filt_q   <= 1'b0;
            db_cnt_q <= '0;
        end else begin
            filt_q   <= filt_d;
            db_cnt_q <= db_cnt_d;
        end
    end

    assign level_s = filt_q;
`else
    assign level_s = sync_q;
`endif

    state_e           state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [3:0]       pattern_q, pattern_d;
    logic [2:0]       sym_cnt_q, sym_cnt_d;
    logic             overflow_q, overflow_d;
    logic [2:0]       letter_q, letter_d;
    logic             letter_valid_q, letter_valid_d;
    logic             decode_error_q, decode_error_d;
    logic             busy_q, busy_d;
    logic [3:0]       group_s;

    // Next-state logic: duration counting, symbol capture and group decode.
    always_comb begin
        state_d        = state_q;
        count_d        = count_q;
        pattern_d      = pattern_q;
        sym_cnt_d      = sym_cnt_q;
        overflow_d     = overflow_q;
        letter_d       = letter_q;
        letter_valid_d = 1'b0;
        decode_error_d = 1'b0;
        group_s        = decode_group(pattern_q, sym_cnt_q);
        case (state_q)
            ST_IDLE: begin
                count_d = '0;
                if (level_s) begin
                    state_d = ST_MARK;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_MARK: begin
                if (level_s) begin
                    if (count_q != CNT_SAT) begin
                        count_d = count_q + CNT_W'(1);
                    end else begin
                        count_d = count_q;
                    end
                end else begin
                    // A fifth symbol is not stored; it only poisons the group.
                    if (sym_cnt_q == 3'd4) begin
                        overflow_d = 1'b1;
                    end else begin
                        pattern_d[sym_cnt_q[1:0]] = (count_q >= DASH_MIN);
                        sym_cnt_d = sym_cnt_q + 3'd1;
                    end
                    state_d = ST_SPACE;
                    count_d = '0;
                end
            end
            ST_SPACE: begin
                if (level_s) begin
                    state_d = ST_MARK;
                    count_d = '0;
                end else if (count_q == GAP_LAST) begin
                    // Gap just reached two units: the group is complete.
                    state_d = ST_DECODE;
                    count_d = count_q + CNT_W'(1);
                    if (group_s[3] && !overflow_q) begin
                        letter_d       = group_s[2:0];
                        letter_valid_d = 1'b1;
                    end else begin
                        decode_error_d = 1'b1;
                    end
                end else begin
                    count_d = count_q + CNT_W'(1);
                end
            end
            ST_DECODE: begin
                pattern_d  = 4'b0000;
                sym_cnt_d  = 3'd0;
                overflow_d = 1'b0;
                count_d    = '0;
                // A mark starting right now opens the next group without loss.
                if (level_s) begin
                    state_d = ST_MARK;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d    = ST_IDLE;
                count_d    = '0;
                pattern_d  = 4'b0000;
                sym_cnt_d  = 3'd0;
                overflow_d = 1'b0;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // State and registered-output flops.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q        <= ST_IDLE;
            count_q        <= '0;
            pattern_q      <= 4'b0000;
            sym_cnt_q      <= 3'd0;
            overflow_q     <= 1'b0;
            letter_q       <= 3'b000;
            letter_valid_q <= 1'b0;
            decode_error_q <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            count_q        <= count_d;
            pattern_q      <= pattern_d;
            sym_cnt_q      <= sym_cnt_d;
            overflow_q     <= overflow_d;
            letter_q       <= letter_d;
            letter_valid_q <= letter_valid_d;
            decode_error_q <= decode_error_d;
            busy_q         <= busy_d;
        end
    end

    assign letter       = letter_q;
    assign letter_valid = letter_valid_q;
    assign decode_error = decode_error_q;
    assign busy         = busy_q;

endmodule
